cdm16_seq_ctrl: RTL and testbench

- Sequential 16x16 multiplier controller. Time-multiplexes one shared 8x8 multiplier unit, which sits outside this block, across the four partial products LL, HL, LH and HH.
- Recombines the four partial products into a 32-bit result, with either carry-disregard lane addition or exact addition.
- Each partial product picks its multiplier variant (exact or approximate) through mul_sel.
- Serves area-constrained configurations in the approximate-multiplier family where four parallel 8x8 units are too costly.

---
 rtl/cdm16_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cdm16_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdm16_seq_ctrl.sv
// cdm16_seq_ctrl: sequential 16x16 multiply controller. Drives one shared external
// 8x8 multiplier through the LL, HL, LH and HH partial products in turn, optionally
// skipping zero-byte products, and recombines them into a 32-bit result.
module cdm16_seq_ctrl #(
  parameter int unsigned CARRY_MODE = 0,     // 0: carry-disregard lanes, 1: exact sum
  parameter logic [1:0]  SEL_LL     = 2'd2,
  parameter logic [1:0]  SEL_HL     = 2'd1,
  parameter logic [1:0]  SEL_LH     = 2'd1,
  parameter logic [1:0]  SEL_HH     = 2'd0,
  parameter int unsigned ZERO_SKIP  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] R,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic [1:0]  mul_sel,
  input  logic [15:0] mul_r
);

  // State encoding: PP states are partial-product index + 1.
  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPpLl = 3'd1;
  localparam logic [2:0] StPpHl = 3'd2;
  localparam logic [2:0] StPpLh = 3'd3;
  localparam logic [2:0] StPpHh = 3'd4;
  localparam logic [2:0] StDone = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [15:0] a_q, b_q;
  logic [15:0] ll_q, hl_q, lh_q, hh_q;
  logic [31:0] r_q;
  logic        out_valid_q;
  logic [31:0] r_comb;

  // Partial product index: bit 0 selects the high byte of a, bit 1 the high byte of b.
  function automatic logic pp_skip(input logic [1:0] idx, input logic [15:0] a,
                                   input logic [15:0] b);
    logic [7:0] ab;
    logic [7:0] bb;
    ab = idx[0] ? a[15:8] : a[7:0];
    bb = idx[1] ? b[15:8] : b[7:0];
    return (ZERO_SKIP != 0) && ((ab == 8'd0) || (bb == 8'd0));
  endfunction

  // First non-skipped PP state at or after index 'first', or DONE if none remain.
  function automatic logic [2:0] next_pp(input int first, input logic [15:0] a,
                                         input logic [15:0] b);
    logic [2:0] nxt;
    nxt = StDone;
    for (int i = 3; i >= 0; i--) begin
      if ((i >= first) && !pp_skip(i[1:0], a, b)) nxt = 3'(i + 1);
    end
    return nxt;
  endfunction

  // Next-state logic; skip decisions after accept use the registered operands.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = next_pp(0, A, B);
      StPpLl:  state_d = next_pp(1, a_q, b_q);
      StPpHl:  state_d = next_pp(2, a_q, b_q);
      StPpLh:  state_d = next_pp(3, a_q, b_q);
      StPpHh:  state_d = StDone;
      StDone:  if (out_valid_q && out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand bytes and variant select for the shared multiplier; zero outside PP states.
  always_comb begin
    mul_a   = 8'd0;
    mul_b   = 8'd0;
    mul_sel = 2'd0;
    case (state_q)
      StPpLl: begin
        mul_a   = a_q[7:0];
        mul_b   = b_q[7:0];
        mul_sel = SEL_LL;
      end
      StPpHl: begin
        mul_a   = a_q[15:8];
        mul_b   = b_q[7:0];
        mul_sel = SEL_HL;
      end
      StPpLh: begin
        mul_a   = a_q[7:0];
        mul_b   = b_q[15:8];
        mul_sel = SEL_LH;
      end
      StPpHh: begin
        mul_a   = a_q[15:8];
        mul_b   = b_q[15:8];
        mul_sel = SEL_HH;
      end
      default: ;
    endcase
  end

  // Recombination of the four partial products.
  always_comb begin
    logic [7:0]  lane1;
    logic [7:0]  lane2;
    logic [31:0] r_exact;
    lane1   = ll_q[15:8] + hl_q[7:0] + lh_q[7:0];
    lane2   = hl_q[15:8] + lh_q[15:8] + hh_q[7:0];
    r_exact = {16'd0, ll_q} + {8'd0, hl_q, 8'd0} + {8'd0, lh_q, 8'd0} + {hh_q, 16'd0};
    r_comb  = (CARRY_MODE != 0) ? r_exact : {hh_q[15:8], lane2, lane1, ll_q[7:0]};
  end

  // State, operand/lane capture and result register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      ll_q        <= 16'd0;
      hl_q        <= 16'd0;
      lh_q        <= 16'd0;
      hh_q        <= 16'd0;
      r_q         <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q  <= A;
            b_q  <= B;
            ll_q <= 16'd0;
            hl_q <= 16'd0;
            lh_q <= 16'd0;
            hh_q <= 16'd0;
          end
        end
        StPpLl: ll_q <= mul_r;
        StPpHl: hl_q <= mul_r;
        StPpLh: lh_q <= mul_r;
        StPpHh: hh_q <= mul_r;
        StDone: begin
          // First DONE cycle latches the result; it is then held until handshake.
          if (!out_valid_q) begin
            r_q         <= r_comb;
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign R         = r_q;

endmodule

// File: tb/tb_cdm16_seq_ctrl.sv
// Scoreboard bench for cdm16_seq_ctrl. Instance 0: exact mode (CARRY_MODE=1, all
// SEL=0, no zero skip). Instance 1: default parameters. Both use an exact 8x8 model.
module tb_cdm16_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        busy      [2];
  logic [15:0] a_in      [2];
  logic [15:0] b_in      [2];
  logic [15:0] mul_r     [2];
  logic [31:0] r_out     [2];
  logic [7:0]  mul_a     [2];
  logic [7:0]  mul_b     [2];
  logic [1:0]  mul_sel   [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cdm16_seq_ctrl #(
      .CARRY_MODE(g == 0 ? 1 : 0),
      .SEL_LL    (g == 0 ? 2'd0 : 2'd2),
      .SEL_HL    (g == 0 ? 2'd0 : 2'd1),
      .SEL_LH    (g == 0 ? 2'd0 : 2'd1),
      .SEL_HH    (2'd0),
      .ZERO_SKIP (g == 0 ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .A        (a_in[g]),
      .B        (b_in[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .R        (r_out[g]),
      .busy     (busy[g]),
      .mul_a    (mul_a[g]),
      .mul_b    (mul_b[g]),
      .mul_sel  (mul_sel[g]),
      .mul_r    (mul_r[g])
    );
    assign mul_r[g] = {8'd0, mul_a[g]} * {8'd0, mul_b[g]};
  end

  typedef struct {
    int          inst;
    logic [31:0] r;
    int          lat;
    int          acc;
    int          tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (op %0d): got 0x%08h, expected 0x%08h", name, tag, act, exp);
    end
  endtask

  // Pops the scoreboard whenever an instance presents a result that is accepted.
  task automatic monitor();
    logic ov_prev [2];
    for (int g = 0; g < 2; g++) ov_prev[g] = 1'b0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (out_valid[g] === 1'b1) begin
          if (sb_q.size() == 0 || sb_q[0].inst != g) begin
            if (!ov_prev[g]) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_out_valid: inst %0d R=0x%08h, nothing pending",
                       g, r_out[g]);
            end
          end else begin
            if (!ov_prev[g])
              check("latency", sb_q[0].tag, 32'(cyc - sb_q[0].acc), 32'(sb_q[0].lat));
            if (out_ready[g]) begin
              check("R", sb_q[0].tag, r_out[g], sb_q[0].r);
              void'(sb_q.pop_front());
              done_cnt++;
            end else begin
              check("R_hold", sb_q[0].tag, r_out[g], sb_q[0].r);
            end
          end
        end
        ov_prev[g] = (out_valid[g] === 1'b1);
      end
    end
  endtask

  task automatic do_mul(input int g, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_r, input int n_pp, input int tag);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", tag, 32'(in_ready[g]), 32'd1);
    in_valid[g] = 1'b1;
    a_in[g]     = a;
    b_in[g]     = b;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    a_in[g]     = 16'hDEAD;  // operands must come from the registered copy
    b_in[g]     = 16'hBEEF;
    e.inst = g;
    e.r    = exp_r;
    e.lat  = n_pp + 1;
    e.acc  = cyc;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input int budget, input int tag);
    int d0;
    bit got;
    d0  = done_cnt;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done_cnt != d0) got = 1'b1;
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout (op %0d): no result within %0d cycles", tag, budget);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  // Checks mul_sel over the first n PP cycles and the operand bytes of the first one.
  task automatic trace(input int g, input int tag, input int n, input logic [7:0] seq,
                       input logic [7:0] a0, input logic [7:0] b0);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("mul_sel", tag, 32'(mul_sel[g]), 32'(seq[2*i +: 2]));
      if (i == 0) begin
        check("mul_a", tag, 32'(mul_a[g]), 32'(a0));
        check("mul_b", tag, 32'(mul_b[g]), 32'(b0));
      end
    end
  endtask

  task automatic check_idle(input int g, input int tag, input logic [31:0] exp_r,
                            input bit chk_r);
    check("in_ready", tag, 32'(in_ready[g]), 32'd1);
    check("out_valid", tag, 32'(out_valid[g]), 32'd0);
    check("busy", tag, 32'(busy[g]), 32'd0);
    if (chk_r) check("R_reset", tag, r_out[g], exp_r);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      in_valid[g]  = 1'b0;
      out_ready[g] = 1'b1;
      a_in[g]      = 16'd0;
      b_in[g]      = 16'd0;
    end
    fork
      monitor();
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check_idle(g, 0, 32'd0, 1'b1);
      check("mul_a_idle", 0, 32'(mul_a[g]), 32'd0);
      check("mul_sel_idle", 0, 32'(mul_sel[g]), 32'd0);
    end
    rst_n = 1'b1;

    // Exact instance: all four PPs always visited, exact accumulation.
    do_mul(0, 16'h1234, 16'h5678, 32'h0626_0060, 4, 1);
    trace(0, 1, 4, 8'h00, 8'h34, 8'h78);
    wait_done(20, 1);
    do_mul(0, 16'h0012, 16'h0034, 32'h0000_03A8, 4, 2);
    wait_done(20, 2);

    // Default instance: carry-disregard lanes and zero skipping.
    do_mul(1, 16'hFFFF, 16'hFFFF, 32'hFEFD_0001, 4, 3);
    wait_done(20, 3);
    do_mul(1, 16'h0012, 16'h0034, 32'h0000_03A8, 1, 4);
    trace(1, 4, 1, 8'h02, 8'h12, 8'h34);
    wait_done(20, 4);
    do_mul(1, 16'h0000, 16'hABCD, 32'h0000_0000, 0, 5);
    wait_done(20, 5);
    do_mul(1, 16'h1234, 16'h5678, 32'h0625_0060, 4, 6);
    trace(1, 6, 4, 8'h16, 8'h34, 8'h78);
    wait_done(20, 6);
    do_mul(1, 16'h1200, 16'h0034, 32'h0003_A800, 1, 7);
    trace(1, 7, 1, 8'h01, 8'h12, 8'h34);
    wait_done(20, 7);

    // Backpressure: result held 7 cycles, in_valid pulses ignored.
    out_ready[1] = 1'b0;
    do_mul(1, 16'h0102, 16'h0304, 32'h0003_0A08, 4, 8);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid[1] === 1'b1) seen = 1'b1;
    end
    check("bp_out_valid_seen", 8, 32'(seen), 32'd1);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      in_valid[1] = k[0];
      a_in[1]     = 16'hFFFF;
      b_in[1]     = 16'hFFFF;
      @(negedge clk);
      check("bp_in_ready", 8, 32'(in_ready[1]), 32'd0);
      check("bp_out_valid", 8, 32'(out_valid[1]), 32'd1);
    end
    @(posedge clk);
    #1;
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle(1, 8, 32'd0, 1'b0);
    check("bp_sb_empty", 8, 32'(sb_q.size()), 32'd0);
    repeat (8) @(negedge clk);

    // Reset while in PP_LH aborts the operation; nothing is pushed for it.
    in_valid[1] = 1'b1;
    a_in[1]     = 16'h1234;
    b_in[1]     = 16'h5678;
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_reset_sel_lh", 9, 32'(mul_sel[1]), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    check_idle(1, 9, 32'd0, 1'b1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    do_mul(1, 16'h0003, 16'h0005, 32'h0000_000F, 1, 10);
    wait_done(20, 10);
    check("final_sb_empty", 10, 32'(sb_q.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
